// File: rtl/seg_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan controller.
package seg_pkg;

    // Widest display the helpers below can describe; wider displays need a bigger value here.
    localparam int MAX_DIGITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Pin level that lights a digit, given the board's enable polarity.
    function automatic logic an_on_lvl(input logic an_low);
        return ~an_low;
    endfunction

    // Pin level that keeps a digit dark, given the board's enable polarity.
    function automatic logic an_off_lvl(input logic an_low);
        return an_low;
    endfunction

    // Leading-zero blank mask: bit k is set when digits k..digits-1 are all zero
    // and k is not the least significant digit. Lanes at or above 'digits' stay 0.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] bcd,
                                                      input int                      digits);
        logic [MAX_DIGITS-1:0] mask;
        logic                  zeros_above;
        mask        = '0;
        zeros_above = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 0; k--) begin
            if (k < digits) begin
                zeros_above = zeros_above & (bcd[4*k +: 4] == 4'd0);
                mask[k]     = zeros_above & (k != 0);
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_scan_div.sv
// Slot timer for the scan controller: counts the cycles of one digit slot and
// flags the last SHOW cycle, the last slot cycle and the cycle before it.
module seg_scan_div
    import seg_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic show_last,
    output logic slot_last,
    output logic pre_last
);

    localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] SHOW_END   = CW'(DIV - BLANK - 1);
    localparam logic [CW-1:0] SLOT_END   = CW'(DIV - 1);
    localparam logic [CW-1:0] SLOT_PRE   = CW'(DIV - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign show_last = (cnt_q == SHOW_END);
    assign slot_last = (cnt_q == SLOT_END);
    assign pre_last  = (cnt_q == SLOT_PRE);

    // Count through the slot while scanning, wrap at the slot end, hold at zero otherwise.
    always_comb begin
        cnt_d = '0;
        if (run && !slot_last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Slot counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner: snapshots a packed BCD word once per frame,
// then lights one digit at a time with a dark gap between digits, optionally
// suppressing leading zeros. Drives a single external segment decoder.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 8,
    parameter int AN_LOW = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_lz,
    input  logic [4*DIGITS-1:0] i_bcd,
    input  logic [DIGITS-1:0]   i_dp,
    output logic [3:0]          o_num,
    output logic [DIGITS-1:0]   o_an,
    output logic                o_dp,
    output logic                o_frame
);

    localparam int              IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]   IDX_LAST   = IW'(DIGITS - 1);
    localparam logic            AN_ON_LVL  = an_on_lvl(AN_LOW != 0);
    localparam logic            AN_OFF_LVL = an_off_lvl(AN_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_OFF_LVL}};

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   snap_bcd_q, snap_bcd_d;
    logic [DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic                  snap_lz_q, snap_lz_d;
    logic [3:0]            num_q, num_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  dp_q, dp_d;
    logic                  frame_q, frame_d;

    logic                  run;
    logic                  show_last;
    logic                  slot_last;
    logic                  pre_last;

    logic [4*MAX_DIGITS-1:0] bcd_wide;
    logic [MAX_DIGITS-1:0]   mask_w;
    logic [DIGITS-1:0]       blank_d;
    logic [DIGITS-1:0]       onehot_d;
    logic                    lz_mask_unused;

    assign run = (state_q == SHOW) || (state_q == GAP);

    seg_scan_div #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_div (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .run       (run),
        .show_last (show_last),
        .slot_last (slot_last),
        .pre_last  (pre_last)
    );

    // Sequence IDLE -> LOAD -> (SHOW -> GAP) per digit -> LOAD, with enable loss dominating.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (i_en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d    = SHOW;
                idx_d      = '0;
                snap_bcd_d = i_bcd;
                snap_dp_d  = i_dp;
                snap_lz_d  = i_lz;
            end
            SHOW: begin
                if (show_last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (slot_last) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = SHOW;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
        if (!i_en) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    // The frame marker lands on the last GAP cycle of the last digit, so it is armed one cycle early.
    always_comb begin
        frame_d = i_en && run && pre_last && (idx_q == IDX_LAST);
    end

    // Upper lanes of the wide blank mask are always zero and are folded into a sink.
    assign lz_mask_unused = ^mask_w;

    // Work out the next enable, nibble and decimal point from the next state and snapshot.
    always_comb begin
        bcd_wide                 = '0;
        bcd_wide[4*DIGITS-1:0]   = snap_bcd_d;
        mask_w                   = lz_mask(bcd_wide, DIGITS);
        blank_d                  = snap_lz_d ? mask_w[DIGITS-1:0] : '0;
        onehot_d                 = '0;
        an_d                     = AN_OFF;
        num_d                    = num_q;
        dp_d                     = 1'b0;
        if (state_d == SHOW) begin
            num_d = snap_bcd_d[4*idx_d +: 4];
            if (!blank_d[idx_d]) begin
                onehot_d[idx_d] = 1'b1;
                dp_d            = snap_dp_d[idx_d];
            end
            for (int k = 0; k < DIGITS; k++) begin
                an_d[k] = onehot_d[k] ? AN_ON_LVL : AN_OFF_LVL;
            end
        end
    end

    // State, snapshot and registered output flops.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            num_q      <= 4'd0;
            an_q       <= AN_OFF;
            dp_q       <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            num_q      <= num_d;
            an_q       <= an_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
        end
    end

    assign o_num   = num_q;
    assign o_an    = an_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, 10-cycle-slot, 2-cycle-gap,
// active-low-enable configuration.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 10;
    localparam int BLANK  = 2;
    localparam int AN_LOW = 1;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        lz;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic [3:0]  o_num;
    logic [3:0]  o_an;
    logic        o_dp;
    logic        o_frame;

    int testsRun    = 0;
    int testsFailed = 0;

    // One record: inputs held for 'cycles' clock edges, outputs checked after each edge.
    typedef struct {
        logic        en;
        logic        lz;
        logic [15:0] bcd;
        logic [3:0]  dp;
        int          cycles;
        logic [3:0]  an;
        logic [3:0]  num;
        logic        dpOut;
        logic        frame;
    } vec_t;

    vec_t vecs[$];

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .BLANK  (BLANK),
        .AN_LOW (AN_LOW)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_en    (en),
        .i_lz    (lz),
        .i_bcd   (bcd),
        .i_dp    (dp_in),
        .o_num   (o_num),
        .o_an    (o_an),
        .o_dp    (o_dp),
        .o_frame (o_frame)
    );

    // 10-time-unit clock; checks happen 1 unit after each rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Never more than one digit lit, checked on every falling edge while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            testsRun++;
            if ($countones(~o_an) > 1) begin
                testsFailed++;
                $display("[TB] FAIL onehot_an at %0t: o_an=%b has more than one active enable", $time, o_an);
            end
        end
    end

    // Drive the DUT inputs (called between clock edges).
    task automatic applyStimulus(input logic enIn, input logic lzIn, input logic [15:0] bcdIn,
                                 input logic [3:0] dpIn);
        en    = enIn;
        lz    = lzIn;
        bcd   = bcdIn;
        dp_in = dpIn;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs against the expected values in one comparison.
    task automatic checkOutput(input string name, input logic [3:0] expAn, input logic [3:0] expNum,
                               input logic expDp, input logic expFrame);
        testsRun++;
        if (o_an !== expAn || o_num !== expNum || o_dp !== expDp || o_frame !== expFrame) begin
            testsFailed++;
            $display("[TB] FAIL %s: got an=%b num=%h dp=%b frame=%b, want an=%b num=%h dp=%b frame=%b",
                     name, o_an, o_num, o_dp, o_frame, expAn, expNum, expDp, expFrame);
        end
    endtask

    task automatic pushVec(input logic e, input logic l, input logic [15:0] b, input logic [3:0] d,
                           input int n, input logic [3:0] a, input logic [3:0] nm, input logic dpo,
                           input logic fr);
        vec_t v;
        v.en = e; v.lz = l; v.bcd = b; v.dp = d; v.cycles = n;
        v.an = a; v.num = nm; v.dpOut = dpo; v.frame = fr;
        vecs.push_back(v);
    endtask

    // Append the records for one full frame that starts right after a LOAD cycle.
    // nums holds the hand-derived nibble per digit, lit the digits expected to light,
    // dpExp the decimal points expected to appear. bcdLate is driven from digit 1 onward.
    task automatic pushFrame(input logic [15:0] bcdFirst, input logic [15:0] bcdLate,
                             input logic lzIn, input logic [3:0] dpIn, input logic [15:0] nums,
                             input logic [3:0] lit, input logic [3:0] dpExp);
        logic [15:0] bNow;
        logic [3:0]  oneHot;
        logic [3:0]  anExp;
        logic [3:0]  nib;
        for (int d = 0; d < DIGITS; d++) begin
            bNow   = (d == 0) ? bcdFirst : bcdLate;
            oneHot = 4'b0001 << d;
            anExp  = lit[d] ? ~oneHot : 4'b1111;
            nib    = nums[4*d +: 4];
            pushVec(1'b1, lzIn, bNow, dpIn, DIV - BLANK, anExp, nib, dpExp[d], 1'b0);
            if (d < DIGITS - 1) begin
                pushVec(1'b1, lzIn, bNow, dpIn, BLANK, 4'b1111, nib, 1'b0, 1'b0);
            end else begin
                pushVec(1'b1, lzIn, bNow, dpIn, 1, 4'b1111, nib, 1'b0, 1'b0);
                pushVec(1'b1, lzIn, bNow, dpIn, 1, 4'b1111, nib, 1'b0, 1'b1);
                pushVec(1'b1, lzIn, bNow, dpIn, 1, 4'b1111, nib, 1'b0, 1'b0);
            end
        end
    endtask

    // Reset, then the table of full frames, then the enable-drop and async-reset sequences.
    initial begin
        applyStimulus(1'b0, 1'b0, 16'h0000, 4'b0000);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_async", 4'b1111, 4'h0, 1'b0, 1'b0);
        repeat (2) step();
        checkOutput("reset_hold", 4'b1111, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        checkOutput("idle_en0", 4'b1111, 4'h0, 1'b0, 1'b0);

        // First LOAD cycle, then frames of hand-computed expectations.
        pushVec(1'b1, 1'b0, 16'h1234, 4'b0100, 1, 4'b1111, 4'h0, 1'b0, 1'b0);
        pushFrame(16'h1234, 16'h1234, 1'b0, 4'b0100, 16'h1234, 4'b1111, 4'b0100);
        pushFrame(16'h1234, 16'h5678, 1'b0, 4'b0000, 16'h1234, 4'b1111, 4'b0000);
        pushFrame(16'h5678, 16'h5678, 1'b0, 4'b0000, 16'h5678, 4'b1111, 4'b0000);
        pushFrame(16'h0007, 16'h0007, 1'b1, 4'b1111, 16'h0007, 4'b0001, 4'b0001);
        pushFrame(16'h0000, 16'h0000, 1'b1, 4'b0000, 16'h0000, 4'b0001, 4'b0000);
        pushFrame(16'hF0A9, 16'hF0A9, 1'b1, 4'b0010, 16'hF0A9, 4'b1111, 4'b0010);
        pushFrame(16'h0102, 16'h0102, 1'b1, 4'b1000, 16'h0102, 4'b0111, 4'b0000);
        pushFrame(16'h0030, 16'h0030, 1'b1, 4'b0000, 16'h0030, 4'b0011, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].lz, vecs[i].bcd, vecs[i].dp);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                step();
                checkOutput($sformatf("vec%0d_c%0d", i, c), vecs[i].an, vecs[i].num,
                            vecs[i].dpOut, vecs[i].frame);
            end
        end

        // The DUT now sits in LOAD. Run into digit 2's SHOW, then drop the enable.
        applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0000);
        repeat (22) step();
        checkOutput("digit2_show", 4'b1011, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 4'b0000);
        step();
        checkOutput("en_drop_off", 4'b1111, 4'h2, 1'b0, 1'b0);
        for (int c = 0; c < 45; c++) begin
            step();
            checkOutput($sformatf("en_low_c%0d", c), 4'b1111, 4'h2, 1'b0, 1'b0);
        end

        // Re-enable: one LOAD cycle, then digit 0 from a fresh snapshot.
        applyStimulus(1'b1, 1'b0, 16'h4321, 4'b0001);
        step();
        checkOutput("reen_load", 4'b1111, 4'h2, 1'b0, 1'b0);
        step();
        checkOutput("reen_digit0", 4'b1110, 4'h1, 1'b1, 1'b0);

        // Move into digit 0's gap and pull reset between clock edges.
        repeat (8) step();
        checkOutput("gap_before_rst", 4'b1111, 4'h1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_gap", 4'b1111, 4'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        checkOutput("post_rst_load", 4'b1111, 4'h0, 1'b0, 1'b0);
        step();
        checkOutput("post_rst_digit0", 4'b1110, 4'h1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
